// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmit path.
package i2s_pkg;

    localparam int unsigned SAMPLE_W_DEF    = 16;
    localparam int unsigned CLK_DIV_DEF     = 16;
    localparam int unsigned BITS_PER_CH_DEF = 32;
    localparam int unsigned FIFO_DEPTH_DEF  = 4;

    // Left channel occupies the upper half of a stereo frame.
    typedef struct packed {
        logic [SAMPLE_W_DEF-1:0] left;
        logic [SAMPLE_W_DEF-1:0] right;
    } frame_t;

endpackage

// File: rtl/i2s_frame_scheduler_if.sv
// Valid/ready stereo frame stream from the voice mixer to the frame scheduler.
interface i2s_frame_scheduler_if #(
    parameter int unsigned SAMPLE_W = i2s_pkg::SAMPLE_W_DEF
);
    logic [2*SAMPLE_W-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/stereo_sample_fifo.sv
// Synchronous FIFO of stereo frames; caller must not push when full or pop when empty.
module stereo_sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  level_o
);
    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;

    // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AddrW{1'b0}}});
    assign level_o = wr_ptr_q - rd_ptr_q;
    assign rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_i);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Generates I2S bit/word clocks and schedules buffered stereo words onto audio_data
// so each word is stable well before the serializer latches it at the slot boundary.
module i2s_frame_scheduler
    import i2s_pkg::*;
#(
    parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
    parameter int unsigned BITS_PER_CH = BITS_PER_CH_DEF,
    parameter int unsigned FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF
) (
    input  logic                         sys_clock,
    input  logic                         reset,
    input  logic                         enable,
    i2s_frame_scheduler_if.slave         in_if,
    output logic                         bit_clock,
    output logic                         word_clock,
    output logic [SAMPLE_W-1:0]          audio_data,
    output logic                         sample_tick,
    output logic [7:0]                   underrun_count,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
    localparam int unsigned DivW = $clog2(CLK_DIV);
    localparam int unsigned BitW = $clog2(2 * BITS_PER_CH);
    localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast   = BitW'(2 * BITS_PER_CH - 1);
    localparam logic [BitW-1:0] RightAt   = BitW'(BITS_PER_CH / 2);
    localparam logic [BitW-1:0] PopAt     = BitW'(BITS_PER_CH + BITS_PER_CH / 2);
    localparam logic [BitW-1:0] RightSlot = BitW'(BITS_PER_CH);

    logic                  enable_q;
    logic [DivW-1:0]       div_cnt_q, div_cnt_d;
    logic [BitW-1:0]       bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic                  bit_clock_q, bit_clock_d;
    logic                  word_clock_q, word_clock_d;
    logic [SAMPLE_W-1:0]   audio_q, audio_d;
    logic [SAMPLE_W-1:0]   right_q, right_d;
    logic                  tick_q;
    logic [7:0]            underrun_q, underrun_d;
    logic                  div_wrap, fall_edge, pop_req;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [2*SAMPLE_W-1:0] fifo_rdata;

    assign div_wrap    = (div_cnt_q == DivLast);
    assign fall_edge   = enable && bit_clock_q && div_wrap;
    assign bit_cnt_inc = (bit_cnt_q == BitLast) ? '0 : bit_cnt_q + BitW'(1);
    // Enable rising edge preloads the first frame before framing starts.
    assign pop_req     = (enable && !enable_q) || (fall_edge && (bit_cnt_inc == PopAt));
    assign fifo_push   = in_if.in_valid && !fifo_full;
    assign fifo_pop    = pop_req && !fifo_empty;
    assign in_if.in_ready = !fifo_full;

    stereo_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * SAMPLE_W)
    ) u_fifo (
        .clk_i   (sys_clock),
        .rst_ni  (reset),
        .push_i  (fifo_push),
        .wdata_i (in_if.in_data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        div_cnt_d    = '0;
        bit_cnt_d    = '0;
        bit_clock_d  = 1'b0;
        word_clock_d = 1'b0;
        audio_d      = '0;
        right_d      = '0;
        underrun_d   = underrun_q;
        if (pop_req && fifo_empty && (underrun_q != 8'hFF)) begin
            underrun_d = underrun_q + 8'd1;
        end
        if (enable) begin
            div_cnt_d    = div_wrap ? '0 : div_cnt_q + DivW'(1);
            bit_clock_d  = bit_clock_q ^ div_wrap;
            bit_cnt_d    = fall_edge ? bit_cnt_inc : bit_cnt_q;
            word_clock_d = fall_edge ? (bit_cnt_inc >= RightSlot) : word_clock_q;
            audio_d      = audio_q;
            right_d      = right_q;
            if (pop_req) begin
                audio_d = fifo_empty ? '0 : fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
                right_d = fifo_empty ? '0 : fifo_rdata[SAMPLE_W-1:0];
            end else if (fall_edge && (bit_cnt_inc == RightAt)) begin
                audio_d = right_q;
            end
        end
    end

    always_ff @(posedge sys_clock or negedge reset) begin
        if (!reset) begin
            enable_q     <= 1'b0;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            bit_clock_q  <= 1'b0;
            word_clock_q <= 1'b0;
            audio_q      <= '0;
            right_q      <= '0;
            tick_q       <= 1'b0;
            underrun_q   <= '0;
        end else begin
            enable_q     <= enable;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            bit_clock_q  <= bit_clock_d;
            word_clock_q <= word_clock_d;
            audio_q      <= audio_d;
            right_q      <= right_d;
            tick_q       <= pop_req;
            underrun_q   <= underrun_d;
        end
    end

    assign bit_clock      = bit_clock_q;
    assign word_clock     = word_clock_q;
    assign audio_data     = audio_q;
    assign sample_tick    = tick_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scenario bench for i2s_frame_scheduler with a frame scoreboard tracking pushes and pops.
module tb_i2s_frame_scheduler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        bit_clock;
    logic        word_clock;
    logic [15:0] audio_data;
    logic        sample_tick;
    logic [7:0]  underrun_count;
    logic [2:0]  fifo_level;

    int total;
    int bad;
    int k;

    logic [31:0] exp_q[$];
    logic [15:0] exp_left;
    logic [15:0] exp_right;
    int          m_under;

    i2s_frame_scheduler_if #(.SAMPLE_W(16)) in_if ();

    i2s_frame_scheduler #(
        .CLK_DIV     (16),
        .BITS_PER_CH (32),
        .FIFO_DEPTH  (4),
        .SAMPLE_W    (16)
    ) dut (
        .sys_clock      (clk),
        .reset          (rst_n),
        .enable         (enable),
        .in_if          (in_if),
        .bit_clock      (bit_clock),
        .word_clock     (word_clock),
        .audio_data     (audio_data),
        .sample_tick    (sample_tick),
        .underrun_count (underrun_count),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    // Scoreboard: frames queued on accepted pushes, dequeued when a pop attempt shows up.
    always @(posedge clk) begin : sb
        bit          pre_empty;
        logic [31:0] f;
        pre_empty = (exp_q.size() == 0);
        if (rst_n && in_if.in_valid && in_if.in_ready) exp_q.push_back(in_if.in_data);
        #1;
        if (!rst_n) begin
            exp_q.delete();
            m_under   = 0;
            exp_left  = '0;
            exp_right = '0;
        end else if (sample_tick) begin
            if (pre_empty) begin
                exp_left  = '0;
                exp_right = '0;
                if (m_under != 255) m_under++;
            end else begin
                f = exp_q.pop_front();
                exp_left  = f[31:16];
                exp_right = f[15:0];
            end
        end
    end

    function automatic logic [31:0] fr(input int n);
        return {16'h4000 + 16'(n), 16'hC000 + 16'(n)};
    endfunction

    task automatic do_reset();
        rst_n = 0; enable = 0; in_if.in_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic push_frame(input logic [31:0] d, output bit ok);
        bit ready_pre;
        in_if.in_valid = 1; in_if.in_data = d; ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            ready_pre = in_if.in_ready;
            @(negedge clk);
            ok = ready_pre;
        end
        in_if.in_valid = 0;
    endtask

    // One cycle of the incrementing producer used by the flow scenario.
    task automatic cycle();
        bit acc;
        acc = in_if.in_valid && in_if.in_ready;
        @(negedge clk);
        if (acc) begin k++; in_if.in_data = fr(k); end
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 0; in_if.in_valid = 0; in_if.in_data = '0;
        repeat (3) @(negedge clk);
        total++; if (bit_clock !== 1'b0) begin bad++; $display("FAIL rst_bclk got=%b want=0", bit_clock); end
        total++; if (word_clock !== 1'b0) begin bad++; $display("FAIL rst_wclk got=%b want=0", word_clock); end
        total++; if (audio_data !== 16'h0) begin bad++; $display("FAIL rst_audio got=%h want=0", audio_data); end
        total++; if (sample_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", sample_tick); end
        total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL rst_under got=%0d want=0", underrun_count); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
        total++; if (in_if.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", in_if.in_ready); end
    endtask

    task automatic test_clocks_underrun();
        int   tog[4];
        int   wr[2];
        int   nt, nw, tk;
        logic pb, pw;
        tog = '{-1, -1, -1, -1}; wr = '{-1, -1}; nt = 0; nw = 0; tk = -1;
        enable = 1;
        #2 rst_n = 1;
        @(negedge clk);
        total++; if (sample_tick !== 1'b1) begin bad++; $display("FAIL first_pop_tick got=%b want=1", sample_tick); end
        total++; if (audio_data !== 16'h0) begin bad++; $display("FAIL first_pop_audio got=%h want=0", audio_data); end
        total++; if (underrun_count !== 8'd1) begin bad++; $display("FAIL first_pop_under got=%0d want=1", underrun_count); end
        pb = bit_clock; pw = word_clock;
        for (int idx = 1; idx <= 3100; idx++) begin
            @(negedge clk);
            if (bit_clock !== pb && nt < 4) begin tog[nt] = idx; nt++; end
            if (word_clock === 1'b1 && pw === 1'b0 && nw < 2) begin wr[nw] = idx; nw++; end
            if (sample_tick === 1'b1 && tk < 0) tk = idx;
            pb = bit_clock; pw = word_clock;
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tog[i] != 15 + 16 * i) begin
                bad++; $display("FAIL bclk_toggle%0d got=%0d want=%0d", i, tog[i], 15 + 16 * i);
            end
        end
        total++; if (wr[0] != 1023) begin bad++; $display("FAIL wclk_first_rise got=%0d want=1023", wr[0]); end
        total++; if (wr[1] - wr[0] != 2048) begin bad++; $display("FAIL wclk_period got=%0d want=2048", wr[1] - wr[0]); end
        total++; if (tk != 1535) begin bad++; $display("FAIL pop_point got=%0d want=1535", tk); end
        total++; if (underrun_count !== 8'd2) begin bad++; $display("FAIL under_after_frame got=%0d want=2", underrun_count); end
        enable = 0;
    endtask

    task automatic test_frames();
        bit ok1, ok2;
        do_reset();
        push_frame(32'h1234ABCD, ok1);
        push_frame(32'h0F0FF0F0, ok2);
        total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL frames_push got=%b%b want=11", ok1, ok2); end
        total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL frames_level got=%0d want=2", fifo_level); end
        enable = 1;
        @(negedge clk);
        total++; if (audio_data !== 16'h1234) begin bad++; $display("FAIL frames_left0 got=%h want=1234", audio_data); end
        total++; if (audio_data !== exp_left) begin bad++; $display("FAIL frames_sb_left0 got=%h want=%h", audio_data, exp_left); end
        total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL frames_level1 got=%0d want=1", fifo_level); end
        repeat (510) @(negedge clk);
        total++; if (audio_data !== 16'h1234) begin bad++; $display("FAIL frames_left_hold got=%h want=1234", audio_data); end
        @(negedge clk);
        total++; if (audio_data !== 16'hABCD) begin bad++; $display("FAIL frames_right0 got=%h want=abcd", audio_data); end
        repeat (1024) @(negedge clk);
        total++; if (sample_tick !== 1'b1) begin bad++; $display("FAIL frames_tick1 got=%b want=1", sample_tick); end
        total++; if (audio_data !== 16'h0F0F) begin bad++; $display("FAIL frames_left1 got=%h want=0f0f", audio_data); end
        repeat (1024) @(negedge clk);
        total++; if (audio_data !== 16'hF0F0) begin bad++; $display("FAIL frames_right1 got=%h want=f0f0", audio_data); end
        repeat (1024) @(negedge clk);
        total++; if (audio_data !== 16'h0) begin bad++; $display("FAIL frames_underrun_audio got=%h want=0", audio_data); end
        total++; if (underrun_count !== 8'(m_under) || m_under != 1) begin
            bad++; $display("FAIL frames_underrun_cnt got=%0d want=1", underrun_count);
        end
        enable = 0;
    endtask

    task automatic test_flow();
        int   n;
        logic pw;
        do_reset();
        k = 0; in_if.in_data = fr(0); in_if.in_valid = 1;
        for (int i = 0; i < 10; i++) cycle();
        total++; if (in_if.in_ready !== 1'b0) begin bad++; $display("FAIL flow_full_ready got=%b want=0", in_if.in_ready); end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL flow_full_level got=%0d want=4", fifo_level); end
        total++; if (k != 4) begin bad++; $display("FAIL flow_pushes got=%0d want=4", k); end
        enable = 1;
        cycle();
        total++; if (in_if.in_ready !== 1'b1) begin bad++; $display("FAIL flow_freed_ready got=%b want=1", in_if.in_ready); end
        total++; if (fifo_level !== 3'd3) begin bad++; $display("FAIL flow_freed_level got=%0d want=3", fifo_level); end
        total++; if (audio_data !== 16'h4000) begin bad++; $display("FAIL flow_first got=%h want=4000", audio_data); end
        n = 1;
        pw = word_clock;
        for (int i = 0; i < 16000 && n < 8; i++) begin
            cycle();
            if (sample_tick) begin
                total++;
                if (audio_data !== 16'h4000 + 16'(n)) begin
                    bad++; $display("FAIL flow_left%0d got=%h want=%h", n, audio_data, 16'h4000 + 16'(n));
                end
                n++;
            end
            if (word_clock && !pw) begin
                total++;
                if (audio_data !== 16'hC000 + 16'(n - 1)) begin
                    bad++; $display("FAIL flow_right%0d got=%h want=%h", n - 1, audio_data, 16'hC000 + 16'(n - 1));
                end
            end
            pw = word_clock;
        end
        total++; if (n != 8) begin bad++; $display("FAIL flow_frame_pops got=%0d want=8", n); end
        for (int i = 0; i < 1000 && n < 100; i++) begin
            enable = 0; cycle();
            enable = 1; cycle();
            total++;
            if (sample_tick !== 1'b1) begin
                bad++; $display("FAIL flow_fast_tick got=%b want=1", sample_tick);
            end else if (audio_data !== 16'h4000 + 16'(n)) begin
                bad++; $display("FAIL flow_fast_left%0d got=%h want=%h", n, audio_data, 16'h4000 + 16'(n));
            end
            n++;
        end
        total++; if (n != 100) begin bad++; $display("FAIL flow_total_pops got=%0d want=100", n); end
        total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL flow_no_underrun got=%0d want=0", underrun_count); end
        enable = 0; in_if.in_valid = 0;
    endtask

    task automatic test_starve();
        int pops;
        int want;
        do_reset();
        pops = 0;
        for (int i = 0; i < 300; i++) begin
            enable = 0; @(negedge clk);
            enable = 1; @(negedge clk);
            pops++;
            if (pops == 1 || pops == 254 || pops == 255 || pops == 256 || pops == 300) begin
                want = (pops > 255) ? 255 : pops;
                total++;
                if (underrun_count !== 8'(want)) begin
                    bad++; $display("FAIL starve_cnt%0d got=%0d want=%0d", pops, underrun_count, want);
                end
            end
        end
        repeat (1023) @(negedge clk);
        total++; if (word_clock !== 1'b1 || audio_data !== 16'h0) begin
            bad++; $display("FAIL starve_right got=%b/%h want=1/0000", word_clock, audio_data);
        end
        repeat (512) @(negedge clk);
        total++; if (sample_tick !== 1'b1 || audio_data !== 16'h0) begin
            bad++; $display("FAIL starve_left got=%b/%h want=1/0000", sample_tick, audio_data);
        end
        total++; if (underrun_count !== 8'd255) begin bad++; $display("FAIL starve_sat got=%0d want=255", underrun_count); end
        enable = 0;
    endtask

    task automatic test_enable_pause();
        bit ok1, ok2, ok3;
        do_reset();
        push_frame(32'hA1A1A2A2, ok1);
        push_frame(32'hB1B1B2B2, ok2);
        push_frame(32'hC1C1C2C2, ok3);
        total++; if (!(ok1 && ok2 && ok3)) begin bad++; $display("FAIL pause_push got=%b%b%b want=111", ok1, ok2, ok3); end
        enable = 1;
        @(negedge clk);
        total++; if (audio_data !== 16'hA1A1) begin bad++; $display("FAIL pause_leftA got=%h want=a1a1", audio_data); end
        repeat (1099) @(negedge clk);
        total++; if (word_clock !== 1'b1 || audio_data !== exp_right) begin
            bad++; $display("FAIL pause_rightA got=%b/%h want=1/%h", word_clock, audio_data, exp_right);
        end
        enable = 0;
        @(negedge clk);
        total++; if (bit_clock !== 1'b0) begin bad++; $display("FAIL pause_bclk got=%b want=0", bit_clock); end
        total++; if (word_clock !== 1'b0) begin bad++; $display("FAIL pause_wclk got=%b want=0", word_clock); end
        total++; if (audio_data !== 16'h0) begin bad++; $display("FAIL pause_audio got=%h want=0", audio_data); end
        repeat (5) @(negedge clk);
        total++; if (fifo_level !== 3'd2) begin bad++; $display("FAIL pause_level got=%0d want=2", fifo_level); end
        enable = 1;
        @(negedge clk);
        total++; if (sample_tick !== 1'b1 || audio_data !== 16'hB1B1) begin
            bad++; $display("FAIL resume_leftB got=%b/%h want=1/b1b1", sample_tick, audio_data);
        end
        total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL resume_level got=%0d want=1", fifo_level); end
        repeat (511) @(negedge clk);
        total++; if (audio_data !== 16'hB2B2) begin bad++; $display("FAIL resume_rightB got=%h want=b2b2", audio_data); end
    endtask

    task automatic test_async_reset();
        enable = 0; @(negedge clk);
        enable = 1; @(negedge clk);
        enable = 0; @(negedge clk);
        enable = 1; @(negedge clk);
        repeat (20) @(negedge clk);
        in_if.in_valid = 1; in_if.in_data = 32'h5A5A6B6B;
        @(negedge clk);
        in_if.in_valid = 0;
        total++; if (underrun_count !== 8'd1 || fifo_level !== 3'd1) begin
            bad++; $display("FAIL pre_reset_state got=%0d/%0d want=1/1", underrun_count, fifo_level);
        end
        #2 rst_n = 0;
        #1;
        total++; if (bit_clock !== 1'b0) begin bad++; $display("FAIL arst_bclk got=%b want=0", bit_clock); end
        total++; if (word_clock !== 1'b0) begin bad++; $display("FAIL arst_wclk got=%b want=0", word_clock); end
        total++; if (audio_data !== 16'h0) begin bad++; $display("FAIL arst_audio got=%h want=0", audio_data); end
        total++; if (underrun_count !== 8'd0) begin bad++; $display("FAIL arst_under got=%0d want=0", underrun_count); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL arst_level got=%0d want=0", fifo_level); end
        total++; if (in_if.in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b want=1", in_if.in_ready); end
        enable = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    initial begin
        clk = 0; total = 0; bad = 0; k = 0;
        test_reset();
        test_clocks_underrun();
        test_frames();
        test_flow();
        test_starve();
        test_enable_pause();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_frame_scheduler.md
Name: i2s_frame_scheduler

Overview:
Sequencing controller for the I2S transmit serializer. It generates bit_clock and word_clock from sys_clock and buffers stereo sample frames from the synth in a small FIFO. It presents each channel's 16-bit word on audio_data at a safe point in the frame, so the serializer latches it at the next word_clock transition. It sits between the synth voice mixer, which uses a valid/ready producer interface, and the I2S serializer.

Parameters:
CLK_DIV, 16, sys_clock cycles per bit_clock half-period (minimum 2)
BITS_PER_CH, 32, bit_clock periods per channel slot (even, minimum 18)
FIFO_DEPTH, 4, stereo frames buffered (power of two)
SAMPLE_W, 16, bits per channel sample

Ports:
sys_clock  in  1  system clock; all state on its rising edge
reset  in  1  asynchronous, active-low reset; 0 = in reset
enable  in  1  1 = run clocks and framing; 0 = idle
in_data  in  2*SAMPLE_W  stereo frame, {left[31:16], right[15:0]}
in_valid  in  1  producer offers in_data
in_ready  out  1  FIFO can accept a frame
bit_clock  out  1  I2S bit clock to serializer and DAC
word_clock  out  1  0 = left slot, 1 = right slot
audio_data  out  SAMPLE_W  channel word for the serializer
sample_tick  out  1  one-cycle pulse on each FIFO pop attempt
underrun_count  out  8  saturating count of pops from an empty FIFO
fifo_level  out  clog2(FIFO_DEPTH)+1  frames currently held

Behaviour:
- Reset values:
  - bit_clock=0, word_clock=0, audio_data=0, sample_tick=0.
  - underrun_count=0, fifo_level=0, in_ready=1.
  - FIFO is emptied; divider and bit counters are 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while enable=1.
  - At CLK_DIV-1: bit_clock toggles and div_cnt wraps to 0.
- Bit counter:
  - bit_cnt runs 0..2*BITS_PER_CH-1 and advances on each bit_clock falling edge, i.e. the cycle bit_clock goes 1→0.
  - word_clock is registered and equals (bit_cnt >= BITS_PER_CH), so it changes only on a bit_clock falling edge.
- Frame rate = sys_clock / (4*CLK_DIV*BITS_PER_CH). With defaults: bit_clock period 32 cycles, frame 2048 cycles.
- Data schedule (updates occur on the falling-edge cycle):
  - bit_cnt becomes BITS_PER_CH/2: audio_data <= held right word of the current frame.
  - bit_cnt becomes BITS_PER_CH + BITS_PER_CH/2: pop attempt and sample_tick=1. On success, audio_data <= new left and the new right is held internally.
- Underrun (pop attempt with FIFO empty):
  - Left and right words are both forced to 0.
  - underrun_count increments, saturating at 255.
  - sample_tick still pulses.
- Input handshake:
  - in_ready = !full, combinational from registered state.
  - A push occurs when in_valid & in_ready.
  - in_data is sampled on that edge.
  - The producer must hold in_data and in_valid until accepted.
- Simultaneous events:
  - Push and pop in the same cycle: fifo_level is unchanged.
  - Full FIFO plus pop: in_ready stays 0 that cycle; the freed slot becomes visible next cycle.
  - Empty FIFO plus push plus pop attempt: the pop sees pre-edge state, so it is an underrun. The pushed frame is retained.
- Enable:
  - enable=0: div_cnt, bit_cnt, bit_clock, word_clock and audio_data are held at 0. FIFO contents and underrun_count are retained; pushes are still accepted.
  - Rising edge of enable: one immediate pop attempt, with the same rules as above, loads the first left/right words. Framing then starts at bit_cnt=0 (left slot).
  - enable deasserted mid-frame: the current frame is abandoned; the held right word is discarded.
- Reset mid-operation: reset asserted at any time forces all reset values immediately, independent of sys_clock.
- Widths: fifo pointers are clog2(FIFO_DEPTH)+1 bits, wrap-around by natural overflow; full when pointers differ only in MSB.

Decomposition:
- Shared package i2s_pkg:
  - SAMPLE_W, default CLK_DIV and BITS_PER_CH.
  - Stereo frame type: 2*SAMPLE_W, left in the upper half.
- Sub-module stereo_sample_fifo: synchronous FIFO with push/pop/full/empty/level. Reused by the planned receive path.

Test Plan:
- Reset release, enable=1, FIFO empty:
  - bit_clock toggles every 16 cycles.
  - word_clock period is 2048 cycles.
  - First pop is an underrun: audio_data=0 and underrun_count=1.
- Push frames {16'h1234, 16'hABCD} and {16'h0F0F, 16'hF0F0}, then enable:
  - audio_data=1234 in the left slot.
  - audio_data=ABCD from bit_cnt 16 of that frame.
  - Next left word is 0F0F.
- in_valid held high with in_data incrementing:
  - in_ready drops after 4 pushes; fifo_level=4.
  - The cycle of a pop restores in_ready on the following cycle.
  - No frame is lost or duplicated over 100 frames.
- Starve the FIFO for 300 frames: underrun_count saturates at 255; audio_data=0 in both slots.
- Deassert enable mid-right slot, then re-enable:
  - Clocks and audio_data go to 0.
  - The FIFO level is kept.
  - The immediate pop on re-enable presents the oldest frame's left word.
- Assert reset asynchronously between sys_clock edges: outputs reach their reset values before the next edge; fifo_level=0.
